// File: rtl/clk_div.sv
// Programmable integer clock divider with combinational bypass for ratios 0/1 or when disabled.
// Latency: div_q toggles one CLK edge after terminal count; bypass mux switches combinationally.
// Backpressure: none, free-running; ratio changes take effect at the next phase compare.
module clk_div #(
    parameter int RATIO_WD = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLK_EN,
    input  logic [RATIO_WD-1:0] DIV_RATIO,
    output logic                DIV_CLK
);

    localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

    logic                div_mode;
    logic [RATIO_WD-1:0] low_len;
    logic [RATIO_WD-1:0] high_len;
    logic [RATIO_WD-1:0] cnt;
    logic                div_q;

    // Odd ratios put the extra cycle in the high phase.
    always_comb begin
        div_mode = CLK_EN && (DIV_RATIO >= TWO);
        low_len  = DIV_RATIO >> 1;
        high_len = DIV_RATIO - low_len;
    end

    // >= rather than == so a shrunk ratio ends the current phase instead of wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (!div_mode) begin
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (!div_q && (cnt >= (low_len - ONE))) begin
            div_q <= 1'b1;
            cnt   <= '0;
        end else if (div_q && (cnt >= (high_len - ONE))) begin
            div_q <= 1'b0;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + ONE;
        end
    end

    assign DIV_CLK = div_mode ? div_q : CLK;

endmodule

// File: tb/tb_clk_div.sv
// Directed self-checking bench for clk_div: bypass, divide ratios, ratio change and mid-phase reset.
module tb_clk_div;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [4:0] div_ratio;
    logic       div_clk;

    int n_tests;
    int n_fail;

    clk_div #(.RATIO_WD(5)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CLK_EN    (clk_en),
        .DIV_RATIO (div_ratio),
        .DIV_CLK   (div_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output level just after rising edge k (k=1 is the first edge in divide mode):
    // low for the first L-1 edges, then H high edges and L low edges repeating.
    function automatic logic exp_div(input int n, input int k);
        int l;
        int h;
        l = n / 2;
        h = n - l;
        if (k < l) return 1'b0;
        return ((k - l) % n) < h;
    endfunction

    // Leaves bypass (which clears div_q/cnt) and enters divide mode right after an edge.
    task automatic enter_div(input int n);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        div_ratio = 5'(n);
        clk_en    = 1'b1;
    endtask

    task automatic run_div(input string tag, input int n, input int edges);
        for (int k = 1; k <= edges; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_e%0d", tag, k), {7'd0, div_clk}, {7'd0, exp_div(n, k)});
        end
    endtask

    task automatic check_bypass(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hi%0d", tag, k), {7'd0, div_clk}, 8'd1);
            @(negedge clk);
            #1;
            check($sformatf("%s_lo%0d", tag, k), {7'd0, div_clk}, 8'd0);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        clk_en    = 1'b1;
        div_ratio = 5'd4;

        // Reset in divide mode: output held low, state cleared.
        #2;
        check("rst_div_low", {7'd0, div_clk}, 8'd0);
        check("rst_cnt", {3'd0, dut.cnt}, 8'd0);
        check("rst_divq", {7'd0, dut.div_q}, 8'd0);
        @(posedge clk);
        #1;
        check("rst_div_low_edge", {7'd0, div_clk}, 8'd0);

        // Reset in bypass: output follows CLK.
        clk_en = 1'b0;
        #1;
        check("rst_bypass_hi", {7'd0, div_clk}, 8'd1);
        @(negedge clk);
        #1;
        check("rst_bypass_lo", {7'd0, div_clk}, 8'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;

        // Disabled with a valid ratio: pass-through, state stays cleared.
        div_ratio = 5'd9;
        check_bypass("dis", 20);
        check("dis_cnt", {3'd0, dut.cnt}, 8'd0);
        check("dis_divq", {7'd0, dut.div_q}, 8'd0);

        // Ratios 1 and 0 bypass even when enabled.
        clk_en    = 1'b1;
        div_ratio = 5'd1;
        check_bypass("r1", 5);
        div_ratio = 5'd0;
        check_bypass("r0", 5);
        check("r0_cnt", {3'd0, dut.cnt}, 8'd0);

        enter_div(2);
        run_div("r2", 2, 8);
        enter_div(3);
        run_div("r3", 3, 30);
        enter_div(4);
        run_div("r4", 4, 16);
        enter_div(5);
        run_div("r5", 5, 20);
        enter_div(31);
        run_div("r31", 31, 62);

        // Ratio 5 -> 2 in the middle of a high phase.
        enter_div(5);
        run_div("chg_pre", 5, 3);
        check("chg_in_high", {7'd0, div_clk}, 8'd1);
        div_ratio = 5'd2;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("chg_e%0d", k), {7'd0, div_clk}, (k % 2 == 0) ? 8'd1 : 8'd0);
        end

        // Reset mid-high-phase drops the output immediately.
        enter_div(5);
        run_div("mrst_pre", 5, 3);
        check("mrst_in_high", {7'd0, div_clk}, 8'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_low_now", {7'd0, div_clk}, 8'd0);
        @(posedge clk);
        #1;
        check("mrst_held", {7'd0, div_clk}, 8'd0);
        rst = 1'b1;
        run_div("mrst_post", 5, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div.md
# clk_div

Programmable integer clock divider. It produces a divided clock `DIV_CLK` from the system clock `CLK`, using a 5-bit runtime ratio `DIV_RATIO`. It feeds ratio-scaled clocks to downstream blocks, such as UART TX/RX oversampling domains. When disabled, or when the ratio is 0 or 1, the block passes `CLK` through unchanged.

## Interface
- `RATIO_WD`, default 5: width of `DIV_RATIO` and of the internal phase counter.
- `CLK`  in  1: system clock; all state is updated on the rising edge.
- `RST`  in  1: reset, asynchronous, active-low.
- `CLK_EN`  in  1: divider enable; 0 selects bypass.
- `DIV_RATIO`  in  `RATIO_WD`: division ratio N, unsigned; sampled every cycle.
- `DIV_CLK`  out  1: divided clock, or `CLK` in bypass.

## Operation
- Divide mode is active when `CLK_EN`=1 and N>=2. Otherwise the block is in bypass.
- Bypass behaviour:
  - `DIV_CLK` = `CLK`, through a combinational mux.
  - The internal output register `div_q` and the counter `cnt` are held at 0, so re-entering divide mode always starts from a clean low phase.
- Phase lengths in divide mode:
  - High phase H = ceil(N/2) cycles.
  - Low phase L = floor(N/2) cycles.
  - Output period = N cycles of `CLK`.
  - Even N gives a 50% duty cycle. Odd N has a high phase one cycle longer than the low phase.
- Per rising edge in divide mode:
  - If `div_q`=0 and `cnt` >= L-1: set `div_q` <- 1 and `cnt` <- 0.
  - Else if `div_q`=1 and `cnt` >= H-1: set `div_q` <- 0 and `cnt` <- 0.
  - Else: `cnt` <- `cnt`+1.
- `DIV_CLK` = `div_q` in divide mode.
- The `>=` compare means a ratio change mid-phase never overruns. A shrunk ratio ends the current phase on the next edge. A grown ratio extends the current phase. The new H and L apply from the next compare.
- `cnt` is `RATIO_WD` bits wide and cannot wrap, since L-1 and H-1 are at most 15.
- Reset (`RST`=0, asynchronous):
  - `div_q` = 0 and `cnt` = 0.
  - `DIV_CLK` = 0 if in divide mode, otherwise it follows `CLK`.

## Timing
- `div_q` changes only on `CLK` rising edges, registered with one edge of latency from the terminal count.
- The first `DIV_CLK` rise after reset release, or after entering divide mode, comes on the L-th rising edge.
  - N=2: 1st edge.
  - N=3: 1st edge.
  - N=4: 2nd edge.
- Bypass entry or exit takes effect combinationally, in the same cycle that `CLK_EN` or `DIV_RATIO` changes.
- A glitch at the mux switchover is permitted.
- Reset assertion mid-operation forces `DIV_CLK` low immediately in divide mode.
- Deassertion is released on the next rising edge.
- `DIV_RATIO`=31: H=16, L=15, period 31 cycles.

## Structure
- Single module with no sub-modules:
  - Registered counter and output flop.
  - One combinational bypass mux.
- H and L are derived combinationally:
  - L = `DIV_RATIO` >> 1.
  - H = `DIV_RATIO` - L.
- No shared package is required. `RATIO_WD` is the only constant and stays a module parameter.

## Test plan
All scenarios use a `CLK` period of 10 time units.
- Disable: `CLK_EN`=0 with any ratio, for 20 cycles -> `DIV_CLK` equals `CLK` at every sample. `cnt` and `div_q` stay 0.
- Ratio 1 and ratio 0 with `CLK_EN`=1 -> `DIV_CLK` equals `CLK` (bypass).
- Ratio 2 -> `DIV_CLK` toggles on every rising edge. Period 20, high 10, low 10; first rise on the 1st edge.
- Ratio 3 -> period 30, high 20, low 10, repeating with no drift over 10 periods.
- Ratio 4 -> period 40, 50% duty. Ratio 5 -> period 50, high 30, low 20.
- Mid-operation:
  - Switch the ratio from 5 to 2 during a high phase -> that phase ends on the next edge, then the output runs at period 20.
  - Assert `RST` low mid-high-phase -> `DIV_CLK` goes to 0 immediately. After release, the first rise comes on the L-th edge.
